// File: rtl/dma_burst_sched.sv
// DMA burst scheduler: splits a descriptor into AXI-legal read and write bursts
// (4 KB and max-burst bounded) and tracks outstanding write responses.
module dma_burst_sched #(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_BEATS       = 16,
  parameter int MAX_OUTSTANDING = 8,
  localparam int OW             = $clog2(DATA_WIDTH / 8)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dma_go_i,
  input  logic [ADDR_WIDTH-1:0] desc_src_addr_i,
  input  logic [ADDR_WIDTH-1:0] desc_dst_addr_i,
  input  logic [ADDR_WIDTH-1:0] desc_num_bytes_i,
  input  logic                  abort_i,
  output logic                  rd_req_valid_o,
  output logic [ADDR_WIDTH-1:0] rd_req_addr_o,
  output logic [7:0]            rd_req_alen_o,
  output logic [OW-1:0]         rd_req_head_o,
  output logic [OW-1:0]         rd_req_tail_o,
  input  logic                  rd_req_ready_i,
  output logic                  wr_req_valid_o,
  output logic [ADDR_WIDTH-1:0] wr_req_addr_o,
  output logic [7:0]            wr_req_alen_o,
  output logic [OW-1:0]         wr_req_head_o,
  output logic [OW-1:0]         wr_req_tail_o,
  input  logic                  wr_req_ready_i,
  input  logic                  wr_resp_i,
  output logic                  clear_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            dbg_state_o
);

  localparam int BYTES       = DATA_WIDTH / 8;
  localparam int BURST_BYTES = MAX_BEATS * BYTES;
  localparam int OUT_W       = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] chunk;
    logic [7:0]            alen;
    logic [OW-1:0]         head;
    logic [OW-1:0]         tail;
  } burst_t;

  // Next burst from the current address and remaining count.
  function automatic burst_t burst_calc(input logic [ADDR_WIDTH-1:0] addr,
                                        input logic [ADDR_WIDTH-1:0] rem);
    logic [ADDR_WIDTH-1:0] to_4k, to_max, chunk, end_b, beats;
    burst_t b;
    to_4k  = ADDR_WIDTH'(4096) - ADDR_WIDTH'(addr[11:0]);
    to_max = ADDR_WIDTH'(BURST_BYTES) - ADDR_WIDTH'(addr[OW-1:0]);
    chunk  = rem;
    if (to_4k < chunk) chunk = to_4k;
    if (to_max < chunk) chunk = to_max;
    end_b   = ADDR_WIDTH'(addr[OW-1:0]) + chunk;
    beats   = (end_b + ADDR_WIDTH'(BYTES - 1)) >> OW;
    b.chunk = chunk;
    b.alen  = 8'(beats - ADDR_WIDTH'(1));
    b.head  = addr[OW-1:0];
    b.tail  = OW'(ADDR_WIDTH'(0) - end_b);
    return b;
  endfunction

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] rd_addr, rd_rem, rd_chunk;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_rem, wr_chunk;
  logic [OUT_W-1:0]      out_cnt;
  burst_t                rd_nxt, wr_nxt;
  logic                  active, go_acc, abort_acc;
  logic                  rd_hs, wr_hs, rd_issue, wr_issue, resp_acc;

  // Request channels: a transfer happens on a rising edge with valid && ready.
  // Once valid is high the fields stay frozen and valid stays high until that
  // transfer; valid then drops for at least one cycle before the next burst.
  assign active    = (state == RUN) || (state == DRAIN);
  assign go_acc    = (state == IDLE) && dma_go_i;
  assign abort_acc = active && abort_i;
  assign rd_hs     = rd_req_valid_o && rd_req_ready_i;
  assign wr_hs     = wr_req_valid_o && wr_req_ready_i;
  assign resp_acc  = wr_resp_i && (out_cnt != '0);
  assign rd_nxt    = burst_calc(rd_addr, rd_rem);
  assign wr_nxt    = burst_calc(wr_addr, wr_rem);
  assign rd_issue  = (state == RUN) && !rd_req_valid_o && (rd_rem != '0);
  assign wr_issue  = (state == RUN) && !wr_req_valid_o && (wr_rem != '0) &&
                     (out_cnt < OUT_W'(MAX_OUTSTANDING));

  // clear_o is combinational so the aligner FIFOs clear in the go/abort cycle.
  assign clear_o     = rstn && (go_acc || abort_acc);
  assign busy_o      = active;
  assign dbg_state_o = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (dma_go_i) state <= (desc_num_bytes_i == '0) ? DONE : RUN;
        end
        RUN: begin
          if (abort_i) state <= IDLE;
          else if ((rd_rem == '0) && (wr_rem == '0)) state <= DRAIN;
        end
        DRAIN: begin
          if (abort_i) state <= IDLE;
          else if (out_cnt == '0) state <= DONE;
        end
        DONE: begin
          done_o <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_addr        <= '0;
      rd_rem         <= '0;
      rd_chunk       <= '0;
      rd_req_valid_o <= 1'b0;
      rd_req_addr_o  <= '0;
      rd_req_alen_o  <= '0;
      rd_req_head_o  <= '0;
      rd_req_tail_o  <= '0;
    end else if (go_acc) begin
      rd_addr        <= desc_src_addr_i;
      rd_rem         <= desc_num_bytes_i;
      rd_req_valid_o <= 1'b0;
    end else if (abort_acc) begin
      rd_addr        <= '0;
      rd_rem         <= '0;
      rd_req_valid_o <= 1'b0;
    end else if (rd_hs) begin
      rd_addr        <= rd_addr + rd_chunk;
      rd_rem         <= rd_rem - rd_chunk;
      rd_req_valid_o <= 1'b0;
    end else if (rd_issue) begin
      rd_chunk       <= rd_nxt.chunk;
      rd_req_valid_o <= 1'b1;
      rd_req_addr_o  <= {rd_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
      rd_req_alen_o  <= rd_nxt.alen;
      rd_req_head_o  <= rd_nxt.head;
      rd_req_tail_o  <= rd_nxt.tail;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_addr        <= '0;
      wr_rem         <= '0;
      wr_chunk       <= '0;
      wr_req_valid_o <= 1'b0;
      wr_req_addr_o  <= '0;
      wr_req_alen_o  <= '0;
      wr_req_head_o  <= '0;
      wr_req_tail_o  <= '0;
    end else if (go_acc) begin
      wr_addr        <= desc_dst_addr_i;
      wr_rem         <= desc_num_bytes_i;
      wr_req_valid_o <= 1'b0;
    end else if (abort_acc) begin
      wr_addr        <= '0;
      wr_rem         <= '0;
      wr_req_valid_o <= 1'b0;
    end else if (wr_hs) begin
      wr_addr        <= wr_addr + wr_chunk;
      wr_rem         <= wr_rem - wr_chunk;
      wr_req_valid_o <= 1'b0;
    end else if (wr_issue) begin
      wr_chunk       <= wr_nxt.chunk;
      wr_req_valid_o <= 1'b1;
      wr_req_addr_o  <= {wr_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
      wr_req_alen_o  <= wr_nxt.alen;
      wr_req_head_o  <= wr_nxt.head;
      wr_req_tail_o  <= wr_nxt.tail;
    end
  end

  // Responses with nothing outstanding are dropped so the count cannot wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_cnt <= '0;
    end else if (go_acc || abort_acc) begin
      out_cnt <= '0;
    end else if (wr_hs && !resp_acc) begin
      out_cnt <= out_cnt + OUT_W'(1);
    end else if (resp_acc && !wr_hs) begin
      out_cnt <= out_cnt - OUT_W'(1);
    end
  end

endmodule

// File: tb/tb_dma_burst_sched.sv
// Directed bench for dma_burst_sched (B=64, MAX_BEATS=16, MAX_OUTSTANDING=1):
// expected bursts queued per side, compared as each handshake happens.
module tb_dma_burst_sched;

  logic        clk;
  logic        rstn;
  logic        dma_go_i;
  logic [31:0] desc_src_addr_i, desc_dst_addr_i, desc_num_bytes_i;
  logic        abort_i;
  logic        rd_req_valid_o, rd_req_ready_i;
  logic [31:0] rd_req_addr_o;
  logic [7:0]  rd_req_alen_o;
  logic [5:0]  rd_req_head_o, rd_req_tail_o;
  logic        wr_req_valid_o, wr_req_ready_i;
  logic [31:0] wr_req_addr_o;
  logic [7:0]  wr_req_alen_o;
  logic [5:0]  wr_req_head_o, wr_req_tail_o;
  logic        wr_resp_i;
  logic        clear_o, busy_o, done_o;
  logic [1:0]  dbg_state_o;

  int total = 0;
  int bad   = 0;
  int rd_hs_cnt = 0;
  int wr_hs_cnt = 0;
  int done_cnt  = 0;
  logic [51:0] exp_rd_q[$];
  logic [51:0] exp_wr_q[$];
  logic [51:0] rd_got, rd_exp, wr_got, wr_exp;
  int b_rd, b_wr, b_done;

  dma_burst_sched #(
    .DATA_WIDTH(512), .ADDR_WIDTH(32), .MAX_BEATS(16), .MAX_OUTSTANDING(1)
  ) u_dut (
    .clk(clk), .rstn(rstn), .dma_go_i(dma_go_i),
    .desc_src_addr_i(desc_src_addr_i), .desc_dst_addr_i(desc_dst_addr_i),
    .desc_num_bytes_i(desc_num_bytes_i), .abort_i(abort_i),
    .rd_req_valid_o(rd_req_valid_o), .rd_req_addr_o(rd_req_addr_o),
    .rd_req_alen_o(rd_req_alen_o), .rd_req_head_o(rd_req_head_o),
    .rd_req_tail_o(rd_req_tail_o), .rd_req_ready_i(rd_req_ready_i),
    .wr_req_valid_o(wr_req_valid_o), .wr_req_addr_o(wr_req_addr_o),
    .wr_req_alen_o(wr_req_alen_o), .wr_req_head_o(wr_req_head_o),
    .wr_req_tail_o(wr_req_tail_o), .wr_req_ready_i(wr_req_ready_i),
    .wr_resp_i(wr_resp_i), .clear_o(clear_o), .busy_o(busy_o),
    .done_o(done_o), .dbg_state_o(dbg_state_o)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [51:0] pk(input logic [31:0] a, input logic [7:0] l,
                                     input logic [5:0] h, input logic [5:0] t);
    return {a, l, h, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop and compare on every handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (rd_req_valid_o && rd_req_ready_i) begin
        rd_got = {rd_req_addr_o, rd_req_alen_o, rd_req_head_o, rd_req_tail_o};
        total++;
        assert (exp_rd_q.size() > 0) else begin
          bad++;
          $error("FAIL rd_unexpected observed=%0h expected=none", rd_got);
        end
        if (exp_rd_q.size() > 0) begin
          rd_exp = exp_rd_q.pop_front();
          total++;
          assert (rd_got === rd_exp) else begin
            bad++;
            $error("FAIL rd_burst observed=%0h expected=%0h", rd_got, rd_exp);
          end
        end
        rd_hs_cnt++;
      end
      if (wr_req_valid_o && wr_req_ready_i) begin
        wr_got = {wr_req_addr_o, wr_req_alen_o, wr_req_head_o, wr_req_tail_o};
        total++;
        assert (exp_wr_q.size() > 0) else begin
          bad++;
          $error("FAIL wr_unexpected observed=%0h expected=none", wr_got);
        end
        if (exp_wr_q.size() > 0) begin
          wr_exp = exp_wr_q.pop_front();
          total++;
          assert (wr_got === wr_exp) else begin
            bad++;
            $error("FAIL wr_burst observed=%0h expected=%0h", wr_got, wr_exp);
          end
        end
        wr_hs_cnt++;
      end
      if (done_o) done_cnt++;
    end
  end

  // Driver tasks
  task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n,
                       input logic exp_clr, input string tag);
    desc_src_addr_i  = s;
    desc_dst_addr_i  = d;
    desc_num_bytes_i = n;
    dma_go_i = 1'b1;
    #1;
    check(tag, clear_o, exp_clr);
    tick();
    dma_go_i = 1'b0;
  endtask

  task automatic pulse_resp();
    wr_resp_i = 1'b1;
    tick();
    wr_resp_i = 1'b0;
  endtask

  task automatic wait_wr_hs(input int n, input string tag);
    int k = 0;
    while (wr_hs_cnt < n && k < 200) begin
      tick();
      k++;
    end
    check(tag, 64'(wr_hs_cnt >= n), 64'd1);
  endtask

  task automatic wait_wr_valid(input string tag);
    int k = 0;
    while (!wr_req_valid_o && k < 50) begin
      tick();
      k++;
    end
    check(tag, wr_req_valid_o, 1'b1);
  endtask

  task automatic wait_done(input int base, input string tag);
    int k = 0;
    while (done_cnt == base && k < 300) begin
      tick();
      k++;
    end
    check(tag, done_cnt, base + 1);
  endtask

  task automatic mark();
    b_rd   = rd_hs_cnt;
    b_wr   = wr_hs_cnt;
    b_done = done_cnt;
  endtask

  initial begin
    rstn = 1'b0;
    dma_go_i = 1'b0;
    abort_i = 1'b0;
    wr_resp_i = 1'b0;
    rd_req_ready_i = 1'b0;
    wr_req_ready_i = 1'b0;
    desc_src_addr_i = '0;
    desc_dst_addr_i = '0;
    desc_num_bytes_i = '0;
    repeat (2) tick();
    check("rst_ctrl", {rd_req_valid_o, wr_req_valid_o, busy_o, done_o, clear_o, dbg_state_o}, '0);
    check("rst_rd_fields", {rd_req_addr_o, rd_req_alen_o, rd_req_head_o, rd_req_tail_o}, '0);
    check("rst_wr_fields", {wr_req_addr_o, wr_req_alen_o, wr_req_head_o, wr_req_tail_o}, '0);
    rstn = 1'b1;
    tick();

    // Unaligned offsets, single burst each side
    rd_req_ready_i = 1'b1;
    wr_req_ready_i = 1'b1;
    mark();
    exp_rd_q.push_back(pk(32'h1000, 8'd1, 6'd16, 6'd12));
    exp_wr_q.push_back(pk(32'h2000, 8'd1, 6'd0, 6'd28));
    start(32'h1010, 32'h2000, 32'd100, 1'b1, "t1_clear");
    check("t1_busy", busy_o, 1'b1);
    wait_wr_hs(b_wr + 1, "t1_wr_hs");
    pulse_resp();
    wait_done(b_done, "t1_done");
    check("t1_idle", busy_o, 1'b0);
    check("t1_rd_cnt", rd_hs_cnt - b_rd, 1);
    check("t1_q_empty", exp_rd_q.size() + exp_wr_q.size(), 0);

    // 4 KB boundary split on the read side
    mark();
    exp_rd_q.push_back(pk(32'h0FC0, 8'd0, 6'd0, 6'd0));
    exp_rd_q.push_back(pk(32'h1000, 8'd0, 6'd0, 6'd0));
    exp_wr_q.push_back(pk(32'h3000, 8'd1, 6'd0, 6'd0));
    start(32'h0FC0, 32'h3000, 32'd128, 1'b1, "t2_clear");
    wait_wr_hs(b_wr + 1, "t2_wr_hs");
    pulse_resp();
    wait_done(b_done, "t2_done");
    check("t2_rd_cnt", rd_hs_cnt - b_rd, 2);
    check("t2_q_empty", exp_rd_q.size() + exp_wr_q.size(), 0);

    // Max-burst split; done only after the second response
    mark();
    exp_rd_q.push_back(pk(32'h000, 8'd15, 6'd0, 6'd0));
    exp_rd_q.push_back(pk(32'h400, 8'd15, 6'd0, 6'd0));
    exp_wr_q.push_back(pk(32'h000, 8'd15, 6'd0, 6'd0));
    exp_wr_q.push_back(pk(32'h400, 8'd15, 6'd0, 6'd0));
    start(32'h0, 32'h0, 32'd2048, 1'b1, "t3_clear");
    wait_wr_hs(b_wr + 1, "t3_wr_hs1");
    pulse_resp();
    wait_wr_hs(b_wr + 2, "t3_wr_hs2");
    repeat (5) tick();
    check("t3_no_early_done", done_cnt - b_done, 0);
    check("t3_drain_busy", busy_o, 1'b1);
    pulse_resp();
    wait_done(b_done, "t3_done");
    check("t3_rd_cnt", rd_hs_cnt - b_rd, 2);
    check("t3_q_empty", exp_rd_q.size() + exp_wr_q.size(), 0);

    // Zero length: straight to DONE, done_o two cycles after the go cycle
    mark();
    start(32'h100, 32'h200, 32'd0, 1'b1, "t4_clear");
    check("t4_state_done", dbg_state_o, 2'd3);
    check("t4_done_early", done_o, 1'b0);
    tick();
    check("t4_done", done_o, 1'b1);
    check("t4_not_busy", busy_o, 1'b0);
    tick();
    check("t4_done_one_cycle", done_o, 1'b0);
    check("t4_no_reqs", (rd_hs_cnt - b_rd) + (wr_hs_cnt - b_wr), 0);

    // Backpressure, outstanding limit, ignored go and stray response while busy
    mark();
    wr_req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_rd_q.push_back(pk(32'(i * 32'h400), 8'd15, 6'd0, 6'd0));
      exp_wr_q.push_back(pk(32'(i * 32'h400), 8'd15, 6'd0, 6'd0));
    end
    start(32'h0, 32'h0, 32'd3072, 1'b1, "t5_clear");
    wait_wr_valid("t5_wr_valid");
    for (int i = 0; i < 4; i++) begin
      check("t5_hold_fields", {wr_req_addr_o, wr_req_alen_o, wr_req_head_o, wr_req_tail_o},
            pk(32'h0, 8'd15, 6'd0, 6'd0));
      check("t5_hold_valid", wr_req_valid_o, 1'b1);
      tick();
    end
    wr_resp_i = 1'b1;
    start(32'h7000, 32'h8000, 32'd64, 1'b0, "t5_go_ignored");
    wr_resp_i = 1'b0;
    check("t5_hold_after", {wr_req_valid_o, wr_req_addr_o, wr_req_alen_o},
          {1'b1, 32'h0, 8'd15});
    wr_req_ready_i = 1'b1;
    wait_wr_hs(b_wr + 1, "t5_wr_hs1");
    for (int i = 0; i < 8; i++) begin
      check("t5_blocked", wr_req_valid_o, 1'b0);
      tick();
    end
    check("t5_rd_indep", rd_hs_cnt - b_rd, 3);
    pulse_resp();
    wait_wr_hs(b_wr + 2, "t5_wr_hs2");
    pulse_resp();
    wait_wr_hs(b_wr + 3, "t5_wr_hs3");
    pulse_resp();
    wait_done(b_done, "t5_done");
    check("t5_q_empty", exp_rd_q.size() + exp_wr_q.size(), 0);

    // Abort while write request pending, then a new transfer
    mark();
    rd_req_ready_i = 1'b0;
    wr_req_ready_i = 1'b0;
    start(32'h0, 32'h0, 32'd2048, 1'b1, "t6_clear_go");
    wait_wr_valid("t6_wr_valid");
    abort_i = 1'b1;
    #1;
    check("t6_clear_abort", clear_o, 1'b1);
    tick();
    abort_i = 1'b0;
    check("t6_dropped", {rd_req_valid_o, wr_req_valid_o, busy_o, dbg_state_o}, '0);
    repeat (10) tick();
    check("t6_no_done", done_cnt - b_done, 0);
    check("t6_still_idle", {rd_req_valid_o, wr_req_valid_o}, 2'b00);

    mark();
    rd_req_ready_i = 1'b1;
    wr_req_ready_i = 1'b1;
    exp_rd_q.push_back(pk(32'h0E00, 8'd7, 6'd48, 6'd0));
    exp_rd_q.push_back(pk(32'h1000, 8'd11, 6'd0, 6'd32));
    exp_wr_q.push_back(pk(32'h5000, 8'd15, 6'd4, 6'd0));
    exp_wr_q.push_back(pk(32'h5400, 8'd2, 6'd0, 6'd12));
    start(32'h0E30, 32'h5004, 32'd1200, 1'b1, "t7_clear");
    wait_wr_hs(b_wr + 1, "t7_wr_hs1");
    pulse_resp();
    wait_wr_hs(b_wr + 2, "t7_wr_hs2");
    pulse_resp();
    wait_done(b_done, "t7_done");
    check("t7_rd_cnt", rd_hs_cnt - b_rd, 2);
    check("t7_q_empty", exp_rd_q.size() + exp_wr_q.size(), 0);

    // Reset mid-transfer: asynchronous clear, no done afterwards
    mark();
    rd_req_ready_i = 1'b0;
    wr_req_ready_i = 1'b0;
    start(32'h0, 32'h0, 32'd2048, 1'b1, "t8_clear");
    wait_wr_valid("t8_wr_valid");
    #2;
    rstn = 1'b0;
    #1;
    check("t8_async_rst", {rd_req_valid_o, wr_req_valid_o, busy_o, dbg_state_o}, '0);
    repeat (2) tick();
    rstn = 1'b1;
    repeat (15) tick();
    check("t8_no_done", done_cnt - b_done, 0);
    check("t8_quiet", {rd_req_valid_o, wr_req_valid_o, busy_o}, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_burst_sched.md
DMA_BURST_SCHED -- requirements
Module: dma_burst_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512; AXI data width in bits; bytes per beat B = DATA_WIDTH/8, offset width OW = log2(B).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32; byte address width.
REQ-003 SHALL have parameter MAX_BEATS, default 16; maximum beats per burst, legal range 1..256.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 8; maximum number of write bursts issued without a response.
REQ-005 SHALL have port clk, input, 1 bit; the single clock, all state on rising edge.
REQ-006 SHALL have port rstn, input, 1 bit; asynchronous active-low reset.
REQ-007 SHALL have port dma_go_i, input, 1 bit; single-cycle start pulse that samples the descriptor.
REQ-008 SHALL have ports desc_src_addr_i and desc_dst_addr_i, inputs, ADDR_WIDTH bits each; the transfer start addresses.
REQ-009 SHALL have port desc_num_bytes_i, input, ADDR_WIDTH bits; the transfer length in bytes.
REQ-010 SHALL have port abort_i, input, 1 bit; cancels the transfer.
REQ-011 SHALL have outputs rd_req_valid_o (1), rd_req_addr_o (ADDR_WIDTH), rd_req_alen_o (8), rd_req_head_o (OW) and rd_req_tail_o (OW), with input rd_req_ready_i (1); the read-burst request channel.
REQ-012 SHALL have outputs wr_req_valid_o, wr_req_addr_o, wr_req_alen_o, wr_req_head_o and wr_req_tail_o, with input wr_req_ready_i; the write-burst channel, same widths as REQ-011.
REQ-013 SHALL have port wr_resp_i, input, 1 bit; one pulse per completed write burst (B handshake).
REQ-014 SHALL have outputs clear_o (1 bit; one-cycle pulse that clears the aligner FIFOs), busy_o (1 bit) and done_o (1 bit; one-cycle completion pulse).

Function
REQ-015 SHALL implement the FSM states IDLE, RUN, DRAIN and DONE.
REQ-016 In IDLE, a dma_go_i pulse SHALL latch the addresses and length, pulse clear_o in the same cycle, and move to RUN on the next cycle; if num_bytes is 0 it SHALL go to DONE instead.
REQ-017 dma_go_i SHALL be ignored outside IDLE.
REQ-018 The read and write sides SHALL each hold an independent current address and remaining-byte count, and SHALL issue bursts independently of each other.
REQ-019 Per burst: head = addr[OW-1:0]; chunk = min(remaining, 4096 - addr[11:0], MAX_BEATS*B - head); end = head + chunk; alen = ceil(end/B) - 1; tail = (B - end mod B) mod B.
REQ-020 The *_req_addr_o output SHALL be addr with its low OW bits cleared.
REQ-021 The request fields SHALL be registered and held stable while valid is high and ready is low; valid SHALL NOT drop without a handshake.
REQ-022 On a valid&&ready handshake, that side SHALL advance by addr += chunk and remaining -= chunk; the next burst's valid SHALL rise no earlier than the cycle after the handshake.
REQ-023 A side SHALL stop issuing when its remaining count reaches 0.
REQ-024 A write burst SHALL NOT issue while the outstanding counter equals MAX_OUTSTANDING.
REQ-025 The outstanding counter SHALL increment on each write handshake and decrement on each wr_resp_i; when both occur in the same cycle the count SHALL be unchanged.
REQ-026 The FSM SHALL move from RUN to DRAIN when both sides have 0 remaining bytes, and from DRAIN to DONE when the outstanding count is 0.
REQ-027 DONE SHALL assert done_o for one cycle and then return to IDLE.
REQ-028 busy_o SHALL be 1 in RUN and DRAIN.
REQ-029 abort_i in RUN or DRAIN SHALL drop both valids the next cycle, pulse clear_o, zero the counters, and go to IDLE without asserting done_o; abort_i SHALL have priority over dma_go_i.
REQ-030 A wr_resp_i pulse arriving with a zero outstanding count SHALL be ignored, with no underflow.

Reset
REQ-031 On rstn low the FSM SHALL enter IDLE and all outputs, latched addresses and counters SHALL be 0, asynchronously.
REQ-032 Reset asserted mid-transfer SHALL discard the transfer, and no done_o SHALL follow reset release.

Verification (B=64, MAX_BEATS=16)
REQ-033 Offsets: src 0x1010, dst 0x2000, 100 bytes -> one read burst (addr 0x1000, alen 1, head 16, tail 12) and one write burst (addr 0x2000, alen 1, head 0, tail 28), then done_o after 1 wr_resp_i.
REQ-034 4 KB split: src 0x0FC0, dst 0x3000, 128 bytes -> read bursts (0x0FC0, alen 0, head 0, tail 0) then (0x1000, alen 0, head 0, tail 0); one write burst (0x3000, alen 1, head 0, tail 0).
REQ-035 Max-burst split: src 0, dst 0, 2048 bytes -> two bursts per side at 0x000 and 0x400, each alen 15; done_o only after 2 wr_resp_i.
REQ-036 Backpressure and outstanding limit: MAX_OUTSTANDING=1, 3 write bursts with no wr_resp_i -> wr_req_valid_o held low after the first handshake; ready held low keeps the fields stable.
REQ-037 Zero length: go with 0 bytes -> clear_o pulse, done_o 2 cycles later, no requests issued.
REQ-038 Abort: abort_i in RUN with wr_req_valid_o high -> valid low next cycle, clear_o pulse, IDLE, no done_o; a following go is accepted.
